// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port integer register file.
//   - rf_state_e : top-level state (array valid vs. clear sweep in progress)
//   - DATA_W_DEF / ADDR_W_DEF : default register width and address width
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_rdport.sv
// One read port of the register file: zero-register / not-ready / range
// masking, write-to-read bypass (load port beats writeback port) and the
// bypassed busy bit.
// Ports:
//   rd_addr_i  : read address
//   ready_i    : array valid (not sweeping)
//   wr_en_i    : write enables, [0] writeback, [1] load return
//   wr_addr_i  : packed write addresses
//   wr_data_i  : packed write data
//   arr_data_i : array contents at rd_addr_i
//   busy_bit_i : scoreboard bit at rd_addr_i
//   rd_data_o  : read data
//   rd_busy_o  : busy bit, cleared by a same-cycle write to the address
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]   rd_addr_i,
    input  logic                ready_i,
    input  logic [1:0]          wr_en_i,
    input  logic [2*ADDR_W-1:0] wr_addr_i,
    input  logic [2*DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0]   arr_data_i,
    input  logic                busy_bit_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_busy_o
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic in_range;
    logic hit0;
    logic hit1;

    assign in_range = ({1'b0, rd_addr_i} < DEPTH_L);
    assign hit0     = wr_en_i[0] && (wr_addr_i[0 +: ADDR_W] == rd_addr_i);
    assign hit1     = wr_en_i[1] && (wr_addr_i[ADDR_W +: ADDR_W] == rd_addr_i);

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            rd_data_o = '0;
        end else if (!ready_i || !in_range) begin
            rd_data_o = '0;
        end else begin
            if (hit1) begin
                rd_data_o = wr_data_i[DATA_W +: DATA_W];
            end else if (hit0) begin
                rd_data_o = wr_data_i[0 +: DATA_W];
            end else begin
                rd_data_o = arr_data_i;
            end
            // A write landing this cycle retires the pending producer.
            rd_busy_o = busy_bit_i && !(hit0 || hit1);
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with NUM_RD combinational read ports,
// two write ports (writeback [0], load return [1]) with same-cycle bypass,
// a per-register busy scoreboard and an optional hard-wired zero register.
// Storage has no reset; a sweep zeroes one entry per cycle after reset or
// on REG_clear.
// Ports:
//   clk, SYS_reset_n             : clock, async active-low reset
//   REG_clear / REG_ready        : sweep request (idle only) / array valid
//   REG_rd_addr/_data/_busy      : packed read ports
//   REG_wr_en/_addr/_data        : two write ports
//   REG_rsv_en / REG_rsv_addr    : mark a destination busy
//   REG_err                      : sticky same-address dual-write flag
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     SYS_reset_n,
    input  logic                     REG_clear,
    output logic                     REG_ready,
    input  logic [NUM_RD*ADDR_W-1:0] REG_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] REG_rd_data,
    output logic [NUM_RD-1:0]        REG_rd_busy,
    input  logic [1:0]               REG_wr_en,
    input  logic [2*ADDR_W-1:0]      REG_wr_addr,
    input  logic [2*DATA_W-1:0]      REG_wr_data,
    input  logic                     REG_rsv_en,
    input  logic [ADDR_W-1:0]        REG_rsv_addr,
    output logic                     REG_err
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] rf_mem [DEPTH];

    logic [ADDR_W-1:0] wa [2];
    logic [DATA_W-1:0] wd [2];
    logic [1:0]        wr_ok;
    logic              conflict;
    logic              rsv_ok;

    assign REG_ready = (state_q == RF_IDLE);
    assign REG_err   = err_q;

    // A write is accepted only when idle, in range and not aimed at r0.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr
            assign wa[gi]    = REG_wr_addr[gi*ADDR_W +: ADDR_W];
            assign wd[gi]    = REG_wr_data[gi*DATA_W +: DATA_W];
            assign wr_ok[gi] = REG_ready && REG_wr_en[gi]
                             && ({1'b0, wa[gi]} < DEPTH_L)
                             && !((ZERO_REG != 0) && (wa[gi] == '0));
        end
    endgenerate

    assign conflict = wr_ok[0] && wr_ok[1] && (wa[0] == wa[1]);
    assign rsv_ok   = REG_rsv_en && ({1'b0, REG_rsv_addr} < DEPTH_L)
                    && !((ZERO_REG != 0) && (REG_rsv_addr == '0));

    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q <= RF_SWEEP;
            cnt_q   <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            RF_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IX) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (REG_clear) begin
                    state_d = RF_SWEEP;
                    cnt_d   = '0;
                    busy_d  = '0;
                    err_d   = 1'b0;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        if (wr_ok[k]) begin
                            busy_d[wa[k]] = 1'b0;
                        end
                    end
                    // Reserve applied after write-clears: the new producer wins.
                    if (rsv_ok) begin
                        busy_d[REG_rsv_addr] = 1'b1;
                    end
                    if (conflict) begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Unreset storage; load port overrides writeback on a same-address clash.
    always_ff @(posedge clk) begin
        if (state_q == RF_SWEEP) begin
            rf_mem[cnt_q] <= '0;
        end else begin
            if (wr_ok[0] && !conflict) begin
                rf_mem[wa[0]] <= wd[0];
            end
            if (wr_ok[1]) begin
                rf_mem[wa[1]] <= wd[1];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              ra_ok;
            logic [DATA_W-1:0] arr_rd;
            logic              busy_rd;

            assign ra      = REG_rd_addr[gi*ADDR_W +: ADDR_W];
            assign ra_ok   = ({1'b0, ra} < DEPTH_L);
            assign arr_rd  = ra_ok ? rf_mem[ra] : '0;
            assign busy_rd = ra_ok ? busy_q[ra] : 1'b0;

            reg_file_rdport #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .DEPTH    (DEPTH),
                .ZERO_REG (ZERO_REG)
            ) u_rdport (
                .rd_addr_i  (ra),
                .ready_i    (REG_ready),
                .wr_en_i    (REG_wr_en),
                .wr_addr_i  (REG_wr_addr),
                .wr_data_i  (REG_wr_data),
                .arr_data_i (arr_rd),
                .busy_bit_i (busy_rd),
                .rd_data_o  (REG_rd_data[gi*DATA_W +: DATA_W]),
                .rd_busy_o  (REG_rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic        clk;
    logic        SYS_reset_n;
    logic        REG_clear;
    logic        REG_ready;
    logic [9:0]  REG_rd_addr;
    logic [63:0] REG_rd_data;
    logic [1:0]  REG_rd_busy;
    logic [1:0]  REG_wr_en;
    logic [9:0]  REG_wr_addr;
    logic [63:0] REG_wr_data;
    logic        REG_rsv_en;
    logic [4:0]  REG_rsv_addr;
    logic        REG_err;

    reg_file_mp dut (
        .clk          (clk),
        .SYS_reset_n  (SYS_reset_n),
        .REG_clear    (REG_clear),
        .REG_ready    (REG_ready),
        .REG_rd_addr  (REG_rd_addr),
        .REG_rd_data  (REG_rd_data),
        .REG_rd_busy  (REG_rd_busy),
        .REG_wr_en    (REG_wr_en),
        .REG_wr_addr  (REG_wr_addr),
        .REG_wr_data  (REG_wr_data),
        .REG_rsv_en   (REG_rsv_en),
        .REG_rsv_addr (REG_rsv_addr),
        .REG_err      (REG_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 ready, 1 err, 2 rd_data[port], 3 rd_busy[port]
    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: the outputs for the inputs driven after a posedge are
    // settled by the following negedge; every queued expectation is
    // checked there.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = {31'b0, REG_ready};
                1:       act = {31'b0, REG_err};
                2:       act = REG_rd_data[e.port*32 +: 32];
                default: act = {31'b0, REG_rd_busy[e.port]};
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
                         e.name, act, e.exp, $time);
            end else begin
                $display("ok   %s: 0x%08h (t=%0t)", e.name, act, $time);
            end
        end
    end

    task automatic expect_v(input int kind, input int port,
                            input logic [31:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        REG_clear    = 1'b0;
        REG_rd_addr  = '0;
        REG_wr_en    = '0;
        REG_wr_addr  = '0;
        REG_wr_data  = '0;
        REG_rsv_en   = 1'b0;
        REG_rsv_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        REG_rd_addr[p*5 +: 5] = a;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        REG_wr_en[p]            = 1'b1;
        REG_wr_addr[p*5 +: 5]   = a;
        REG_wr_data[p*32 +: 32] = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        REG_rsv_en   = 1'b1;
        REG_rsv_addr = a;
    endtask

    initial begin
        SYS_reset_n = 1'b0;
        idle();

        // ---- reset state ----
        step();
        expect_v(0, 0, 0, "reset_ready");
        expect_v(1, 0, 0, "reset_err");

        // ---- deassert; sweep with writes/reserve/clear that must be ignored ----
        step();
        SYS_reset_n = 1'b1;
        set_wr(0, 5'd9, 32'h0000_AAAA);
        rsv(5'd6);
        REG_clear = 1'b1;
        set_rd(0, 5'd9);
        expect_v(0, 0, 0, "sweep_ready_0");
        for (int i = 1; i < 32; i++) begin
            step();
            expect_v(0, 0, 0, $sformatf("sweep_ready_%0d", i));
            expect_v(2, 0, 0, $sformatf("sweep_rdata_%0d", i));
            expect_v(3, 0, 0, $sformatf("sweep_rbusy_%0d", i));
        end
        step();
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd9);
        expect_v(0, 0, 1, "ready_after_32");
        expect_v(2, 0, 0, "r5_zero");
        expect_v(2, 1, 0, "r9_sweep_write_dropped");
        expect_v(3, 1, 0, "r9_busy_0");
        step();
        idle();
        set_rd(0, 5'd6);
        expect_v(3, 0, 0, "r6_sweep_rsv_dropped");

        // ---- write r3 with same-cycle bypass ----
        step();
        idle();
        set_wr(0, 5'd3, 32'hDEAD_BEEF);
        set_rd(0, 5'd3);
        expect_v(2, 0, 32'hDEAD_BEEF, "r3_bypass");
        step();
        idle();
        set_rd(1, 5'd3);
        expect_v(2, 1, 32'hDEAD_BEEF, "r3_persist");
        expect_v(1, 0, 0, "err_still_0");

        // ---- dual write conflict on r7, then clear ----
        step();
        idle();
        set_wr(0, 5'd7, 32'h0000_1111);
        set_wr(1, 5'd7, 32'h0000_2222);
        set_rd(0, 5'd7);
        expect_v(2, 0, 32'h0000_2222, "r7_bypass_load_wins");
        expect_v(1, 0, 0, "err_before_edge");
        step();
        idle();
        set_rd(0, 5'd7);
        expect_v(2, 0, 32'h0000_2222, "r7_stored_load_wins");
        expect_v(1, 0, 1, "err_set");
        step();
        idle();
        REG_clear = 1'b1;
        set_rd(0, 5'd7);
        expect_v(0, 0, 1, "ready_before_clear");
        expect_v(1, 0, 1, "err_sticky");
        step();
        idle();
        set_rd(0, 5'd7);
        expect_v(0, 0, 0, "clear_ready_0");
        expect_v(1, 0, 0, "clear_err_0");
        expect_v(2, 0, 0, "clear_r7_masked");
        for (int i = 1; i < 32; i++) begin
            step();
            expect_v(0, 0, 0, $sformatf("clear_ready_%0d", i));
        end
        step();
        idle();
        set_rd(0, 5'd7);
        set_rd(1, 5'd3);
        expect_v(0, 0, 1, "clear_ready_back");
        expect_v(2, 0, 0, "r7_cleared");
        expect_v(2, 1, 0, "r3_cleared");

        // ---- reserve r4, write it two cycles later ----
        step();
        idle();
        rsv(5'd4);
        set_rd(0, 5'd4);
        expect_v(3, 0, 0, "r4_busy_issue");
        step();
        idle();
        set_rd(0, 5'd4);
        expect_v(3, 0, 1, "r4_busy_c1");
        step();
        idle();
        set_rd(0, 5'd4);
        expect_v(3, 0, 1, "r4_busy_c2");
        step();
        idle();
        set_wr(1, 5'd4, 32'h0000_0044);
        set_rd(0, 5'd4);
        expect_v(3, 0, 0, "r4_busy_bypass");
        expect_v(2, 0, 32'h0000_0044, "r4_data_bypass");
        step();
        idle();
        set_rd(0, 5'd4);
        expect_v(3, 0, 0, "r4_busy_after");
        expect_v(2, 0, 32'h0000_0044, "r4_data_after");
        // reserve and write together: new producer wins
        step();
        idle();
        set_wr(0, 5'd4, 32'h0000_0045);
        rsv(5'd4);
        set_rd(1, 5'd4);
        expect_v(3, 1, 0, "r4_rsvwr_busy_now");
        expect_v(2, 1, 32'h0000_0045, "r4_rsvwr_data_now");
        step();
        idle();
        set_rd(1, 5'd4);
        expect_v(3, 1, 1, "r4_rsvwr_busy_next");
        expect_v(2, 1, 32'h0000_0045, "r4_rsvwr_data_next");

        // ---- zero register ----
        step();
        idle();
        set_wr(0, 5'd0, 32'h0000_0055);
        rsv(5'd0);
        set_rd(0, 5'd0);
        expect_v(2, 0, 0, "r0_write_bypass_0");
        expect_v(3, 0, 0, "r0_busy_now");
        step();
        idle();
        set_rd(0, 5'd0);
        expect_v(2, 0, 0, "r0_reads_0");
        expect_v(3, 0, 0, "r0_busy_0");

        // ---- two ports, different addresses ----
        step();
        idle();
        set_wr(0, 5'd1, 32'h0000_0011);
        set_wr(1, 5'd2, 32'h0000_0022);
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        expect_v(2, 0, 32'h0000_0011, "r1_bypass");
        expect_v(2, 1, 32'h0000_0022, "r2_bypass");
        step();
        idle();
        set_rd(0, 5'd2);
        set_rd(1, 5'd1);
        expect_v(2, 0, 32'h0000_0022, "r2_stored");
        expect_v(2, 1, 32'h0000_0011, "r1_stored");
        expect_v(1, 0, 0, "err_no_conflict");

        // ---- conflict + reserve, then reset, then reset mid-sweep ----
        step();
        idle();
        set_wr(0, 5'd10, 32'h0000_0001);
        set_wr(1, 5'd10, 32'h0000_0002);
        rsv(5'd8);
        set_rd(0, 5'd8);
        set_rd(1, 5'd10);
        expect_v(3, 0, 0, "r8_busy_issue");
        expect_v(2, 1, 32'h0000_0002, "r10_bypass");
        step();
        idle();
        set_rd(0, 5'd8);
        set_rd(1, 5'd10);
        expect_v(1, 0, 1, "err_set_2");
        expect_v(3, 0, 1, "r8_busy_set");
        expect_v(2, 1, 32'h0000_0002, "r10_stored");
        step();
        SYS_reset_n = 1'b0;
        expect_v(0, 0, 0, "rst_ready");
        expect_v(1, 0, 0, "rst_err");
        step();
        SYS_reset_n = 1'b1;
        expect_v(0, 0, 0, "rst2_ready_0");
        for (int i = 1; i <= 10; i++) begin
            step();
            expect_v(0, 0, 0, $sformatf("partial_ready_%0d", i));
        end
        // sweep now at index 10
        SYS_reset_n = 1'b0;
        expect_v(0, 0, 0, "mid_rst_ready");
        step();
        SYS_reset_n = 1'b1;
        expect_v(0, 0, 0, "resweep_ready_0");
        for (int i = 1; i < 32; i++) begin
            step();
            expect_v(0, 0, 0, $sformatf("resweep_ready_%0d", i));
        end
        step();
        idle();
        set_rd(0, 5'd8);
        set_rd(1, 5'd10);
        expect_v(0, 0, 1, "resweep_ready_1");
        expect_v(3, 0, 0, "r8_busy_after_rst");
        expect_v(2, 1, 0, "r10_after_rst");
        expect_v(1, 0, 0, "err_after_rst");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
